// File: rtl/urv_imem_bridge.sv
// Instruction-fetch buffer with a Wishbone B4 pipelined read master behind it.
// Define URV_IMEM_LINE_BUF_EN to replace the single-word entry with one 4-word line.
module urv_imem_bridge #(
    parameter logic [31:0] g_err_insn = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        flush_i,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic        discard;
    logic        term;
    logic        accept;
    logic        bypass;
    logic        hit;
    logic        last_issue;
    logic        last_beat;
    logic [31:0] beat;
    logic [31:0] hit_data;
    logic [29:0] fetch_word;
    logic [29:0] beat_word;
    logic        unused_addr_bits;

    assign fetch_word       = im_addr_i[31:2];
    assign unused_addr_bits = ^im_addr_i[1:0];

    // A flush in the completion cycle poisons that beat as well as later ones.
    assign term   = wb_cyc_o & (wb_ack_i | wb_err_i);
    assign accept = term & ~discard & ~flush_i;
    assign beat   = wb_err_i ? g_err_insn : wb_dat_i;
    assign bypass = accept & (beat_word == fetch_word);

`ifdef URV_IMEM_LINE_BUF_EN
    logic [27:0] tag;
    logic [3:0]  valid;
    logic [31:0] data [4];
    logic [2:0]  issue_cnt;
    logic [2:0]  ack_cnt;

    assign hit        = valid[fetch_word[1:0]] & (tag == fetch_word[29:2]);
    assign hit_data   = data[fetch_word[1:0]];
    assign beat_word  = {tag, ack_cnt[1:0]};
    assign last_issue = (issue_cnt == 3'd3);
    assign last_beat  = (ack_cnt == 3'd3);

    always_ff @(posedge clk_i) begin
        if (accept)
            data[ack_cnt[1:0]] <= beat;
    end
`else
    logic [29:0] tag;
    logic        valid;
    logic [31:0] data;

    assign hit        = valid & (tag == fetch_word);
    assign hit_data   = data;
    assign beat_word  = wb_adr_o[31:2];
    assign last_issue = 1'b1;
    assign last_beat  = 1'b1;

    always_ff @(posedge clk_i) begin
        if (accept)
            data <= beat;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_adr_o   <= '0;
            im_valid_o <= 1'b0;
            im_data_o  <= '0;
            bus_err_o  <= 1'b0;
            discard    <= 1'b0;
            valid      <= '0;
            tag        <= '0;
`ifdef URV_IMEM_LINE_BUF_EN
            issue_cnt  <= '0;
            ack_cnt    <= '0;
`endif
        end else begin
            bus_err_o <= wb_cyc_o & wb_err_i;

            if (flush_i) begin
                im_valid_o <= 1'b0;
            end else if (bypass) begin
                im_valid_o <= 1'b1;
                im_data_o  <= beat;
            end else if (hit) begin
                im_valid_o <= 1'b1;
                im_data_o  <= hit_data;
            end else begin
                im_valid_o <= 1'b0;
            end

`ifdef URV_IMEM_LINE_BUF_EN
            if (accept)
                valid[ack_cnt[1:0]] <= 1'b1;
            if (term)
                ack_cnt <= ack_cnt + 3'd1;
`else
            if (accept) begin
                valid <= 1'b1;
                tag   <= beat_word;
            end
`endif

            case (state)
                IDLE: begin
                    if (!hit && !flush_i) begin
                        state    <= REQ;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        discard  <= 1'b0;
`ifdef URV_IMEM_LINE_BUF_EN
                        wb_adr_o  <= {fetch_word[29:2], 4'b0000};
                        tag       <= fetch_word[29:2];
                        valid     <= '0;
                        issue_cnt <= '0;
                        ack_cnt   <= '0;
`else
                        wb_adr_o  <= {fetch_word, 2'b00};
`endif
                    end
                end
                REQ: begin
                    if (!wb_stall_i) begin
`ifdef URV_IMEM_LINE_BUF_EN
                        issue_cnt <= issue_cnt + 3'd1;
                        if (!last_issue)
                            wb_adr_o <= wb_adr_o + 32'd4;
`endif
                        if (last_issue) begin
                            wb_stb_o <= 1'b0;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (term && last_beat) begin
                        wb_cyc_o <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush_i) begin
                discard <= 1'b1;
                valid   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_urv_imem_bridge.sv
// Randomized bench for urv_imem_bridge: a pipelined Wishbone slave plus a queue-based
// transaction model of the fetch buffer; honours URV_IMEM_LINE_BUF_EN like the design.
module tb_urv_imem_bridge;

    localparam logic [31:0] ERR_INSN = 32'hDEAD0073;
`ifdef URV_IMEM_LINE_BUF_EN
    localparam int unsigned NB = 4;
`else
    localparam int unsigned NB = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_valid;
    logic        flush;
    logic        bus_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    always #5 clk = ~clk;

    urv_imem_bridge #(.g_err_insn(ERR_INSN)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .im_addr_i  (im_addr),
        .im_data_o  (im_data),
        .im_valid_o (im_valid),
        .flush_i    (flush),
        .bus_err_o  (bus_err),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_adr_o   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err),
        .wb_stall_i (wb_stall)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave memory: fixed content, with the 0x300 line answering with bus errors.
    function automatic logic [31:0] mem_word(input logic [29:0] w);
        if (w == 30'h40)
            return 32'h00000013;
        return {w[13:0], 2'b11, ~w[15:0]} ^ 32'h12345678;
    endfunction

    function automatic logic is_err(input logic [29:0] w);
        return w[29:2] == 28'h30;
    endfunction

    function automatic logic [29:0] line_of(input logic [29:0] w);
        return (NB == 4) ? (w >> 2) : w;
    endfunction

    function automatic logic [1:0] slot_of(input logic [29:0] w);
        return (NB == 4) ? w[1:0] : 2'b00;
    endfunction

    // Reference model: words still to be strobed, words awaiting completion, buffer contents.
    logic [29:0] to_issue[$];
    logic [29:0] to_ack[$];
    logic        m_discard;
    logic [29:0] m_tag;
    logic [3:0]  m_val;
    logic [31:0] m_dat [4];
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_data;
    logic [31:0] e_adr;

    task automatic model_reset();
        to_issue.delete();
        to_ack.delete();
        m_discard = 1'b0;
        m_tag     = '0;
        m_val     = '0;
        e_valid   = 1'b0;
        e_err     = 1'b0;
        e_data    = '0;
        e_adr     = '0;
    endtask

    task automatic model_step(input logic r, input logic fl, input logic ack, input logic err,
                              input logic stall, input logic [31:0] dat, input logic [31:0] addr);
        logic        busy, term, drop, hit, bypass;
        logic [29:0] fw, w, base;
        logic [31:0] beat;
        if (r) begin
            model_reset();
        end else begin
            fw     = addr[31:2];
            busy   = (to_issue.size() + to_ack.size()) != 0;
            term   = busy && (ack || err) && (to_ack.size() != 0);
            beat   = err ? ERR_INSN : dat;
            drop   = m_discard || fl;
            hit    = m_val[slot_of(fw)] && (m_tag == line_of(fw));
            bypass = term && !drop && (to_ack[0] == fw);
            e_err  = busy && err;
            if (fl)
                e_valid = 1'b0;
            else if (bypass) begin
                e_valid = 1'b1;
                e_data  = beat;
            end else if (hit) begin
                e_valid = 1'b1;
                e_data  = m_dat[slot_of(fw)];
            end else
                e_valid = 1'b0;
            if (term) begin
                w = to_ack.pop_front();
                if (!drop) begin
                    if (NB == 1)
                        m_tag = w;
                    m_val[slot_of(w)] = 1'b1;
                    m_dat[slot_of(w)] = beat;
                end
            end
            if (to_issue.size() != 0 && !stall)
                to_ack.push_back(to_issue.pop_front());
            if (!busy && !hit && !fl) begin
                base = (NB == 4) ? {fw[29:2], 2'b00} : fw;
                for (int unsigned i = 0; i < NB; i++)
                    to_issue.push_back(base + 30'(i));
                if (NB == 4) begin
                    m_tag = line_of(fw);
                    m_val = '0;
                end
                m_discard = 1'b0;
            end
            if (fl) begin
                m_discard = 1'b1;
                m_val     = '0;
            end
            if (to_issue.size() != 0)
                e_adr = {to_issue[0], 2'b00};
        end
    endtask

    logic [29:0] sl_w[$];
    int          sl_due[$];
    logic [31:0] walk;
    logic [29:0] sw;
    logic        rst_v, directed;
    int          dummy_due;

    initial begin
        rst      = 1'b1;
        im_addr  = 32'h100;
        flush    = 1'b0;
        wb_dat   = '0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_stall = 1'b0;
        walk     = 32'h100;
        model_reset();
        repeat (2) @(posedge clk);

        for (int cyc_n = 0; cyc_n < 4000; cyc_n++) begin
            @(negedge clk);
            check_val("im_valid", 32'(im_valid), 32'(e_valid));
            check_val("im_data", im_data, e_data);
            check_val("wb_cyc", 32'(wb_cyc), 32'((to_issue.size() + to_ack.size()) != 0));
            check_val("wb_stb", 32'(wb_stb), 32'(to_issue.size() != 0));
            check_val("wb_adr", wb_adr, e_adr);
            check_val("bus_err", 32'(bus_err), 32'(e_err));
            if (cyc_n == 11) begin
                check_val("first_fetch_valid", 32'(im_valid), 32'd1);
                check_val("first_fetch_data", im_data, 32'h00000013);
            end
            if (cyc_n == 23) begin
                check_val("err_fetch_valid", 32'(im_valid), 32'd1);
                check_val("err_fetch_data", im_data, ERR_INSN);
            end

            directed = cyc_n < 24;
            rst_v    = !directed && ($urandom_range(0, 199) == 0);
            if (cyc_n < 12)
                walk = 32'h100;
            else if (cyc_n < 24)
                walk = 32'h300;
            else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: walk = walk;
                    6, 7:             walk = walk + 32'd4;
                    default:          walk = 32'h100 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 3) << 2);
                endcase
                if (walk > 32'h500)
                    walk = 32'h400;
            end

            wb_ack = 1'b0;
            wb_err = 1'b0;
            wb_dat = $urandom();
            if (wb_cyc && sl_w.size() != 0 && sl_due[0] <= cyc_n) begin
                sw        = sl_w.pop_front();
                dummy_due = sl_due.pop_front();
                if (is_err(sw))
                    wb_err = 1'b1;
                else begin
                    wb_ack = 1'b1;
                    wb_dat = mem_word(sw);
                end
            end else if (!wb_cyc && !directed && $urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    wb_ack = 1'b1;
                else
                    wb_err = 1'b1;
            end
            wb_stall = !directed && ($urandom_range(0, 9) < 3);
            if (wb_cyc && wb_stb && !wb_stall) begin
                sl_w.push_back(wb_adr[31:2]);
                sl_due.push_back(cyc_n + (directed ? 2 : int'($urandom_range(1, 3))));
            end
            if (directed)
                flush = 1'b0;
            else if (wb_cyc && (wb_ack || wb_err))
                flush = ($urandom_range(0, 5) == 0);
            else
                flush = ($urandom_range(0, 39) == 0);
            if (rst_v) begin
                sl_w.delete();
                sl_due.delete();
            end
            rst     = rst_v;
            im_addr = walk | 32'($urandom_range(0, 3));
            model_step(rst, flush, wb_ack, wb_err, wb_stall, wb_dat, im_addr);
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
